update_scheduler: RTL and testbench

Per-frame game-logic scheduler for the 1280x1024 display pipeline. It detects entry into vertical blanking from the VGA controller's row counter and takes a snapshot of which game objects (ship, bullets, enemies, score) request an update. It then grants the shared update window to them one at a time, in fixed index order, with a done handshake and a per-slot timeout. The block sits between the VGA controller and the object modules, so object state never changes while visible pixels are being drawn.

---
 rtl/update_scheduler.sv | 142 ++++++++++++++
 tb/tb_update_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/update_scheduler.sv
// Frame-level update scheduler. On entry into vertical blank it snapshots the object
// requests and grants the update window to one object at a time, lowest index first.
module update_scheduler #(
  parameter int N_REQ     = 4,
  parameter int VER_FIELD = 1023,
  parameter int TIMEOUT   = 4096
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [10:0]      display_row,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  input  logic             clear_overrun,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             frame_tick,
  output logic [15:0]      frame_count,
  output logic [N_REQ-1:0] overrun
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [10:0]   VF   = 11'(VER_FIELD);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_GRANT, S_END} state_e;

  state_e           state_q, state_d;
  logic             vb, vb_q;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ov_q, ov_d;
  logic             busy_q, busy_d;
  logic             tick_q, tick_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    pick;

  assign vb = display_row > VF;

  // Lowest set pending bit wins; scanning downward leaves the lowest index last.
  always_comb begin
    pick = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (pending_q[k]) pick = IW'(k);
  end

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    grant_d       = grant_q;
    busy_d        = busy_q;
    tick_d        = 1'b0;
    frame_count_d = frame_count_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    ov_d          = clear_overrun ? '0 : ov_q;
    case (state_q)
      S_IDLE: begin
        if (vb && !vb_q) begin
          pending_d = req;
          busy_d    = 1'b1;
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (pending_q == '0) begin
          state_d = S_END;
        end else if (!vb) begin
          ov_d      = ov_d | pending_q;
          pending_d = '0;
          state_d   = S_END;
        end else begin
          pending_d[pick] = 1'b0;
          grant_d         = N_REQ'(1) << pick;
          idx_d           = pick;
          cnt_d           = '0;
          state_d         = S_GRANT;
        end
      end
      S_GRANT: begin
        cnt_d = cnt_q + 1'b1;
        // done beats timeout beats vblank abort
        if (done[idx_q]) begin
          grant_d = '0;
          state_d = S_SCAN;
        end else if (cnt_q == TLIM) begin
          grant_d     = '0;
          ov_d[idx_q] = 1'b1;
          state_d     = S_SCAN;
        end else if (!vb) begin
          grant_d     = '0;
          ov_d        = ov_d | pending_q;
          ov_d[idx_q] = 1'b1;
          pending_d   = '0;
          state_d     = S_END;
        end
      end
      S_END: begin
        tick_d        = 1'b1;
        frame_count_d = frame_count_q + 16'd1;
        busy_d        = 1'b0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      vb_q          <= 1'b0;
      pending_q     <= '0;
      grant_q       <= '0;
      busy_q        <= 1'b0;
      tick_q        <= 1'b0;
      frame_count_q <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      ov_q          <= '0;
    end else begin
      state_q       <= state_d;
      vb_q          <= vb;
      pending_q     <= pending_d;
      grant_q       <= grant_d;
      busy_q        <= busy_d;
      tick_q        <= tick_d;
      frame_count_q <= frame_count_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      ov_q          <= ov_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign frame_tick  = tick_q;
  assign frame_count = frame_count_q;
  assign overrun     = ov_q;

endmodule

// File: tb/tb_update_scheduler.sv
// Directed bench for update_scheduler: full round, timeout, vblank abort, empty
// snapshot, coincident events, frame counter wrap and reset mid-grant.
module tb_update_scheduler;

  logic        clock;
  logic        reset;
  logic [10:0] display_row;
  logic [3:0]  req;
  logic [3:0]  done;
  logic        clear_overrun;
  logic [3:0]  grant;
  logic        busy;
  logic        frame_tick;
  logic [15:0] frame_count;
  logic [3:0]  overrun;

  int checks = 0;
  int errors = 0;

  update_scheduler #(.N_REQ(4), .VER_FIELD(1023), .TIMEOUT(4096)) dut (
    .clock(clock), .reset(reset), .display_row(display_row), .req(req),
    .done(done), .clear_overrun(clear_overrun), .grant(grant), .busy(busy),
    .frame_tick(frame_tick), .frame_count(frame_count), .overrun(overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_g [3];
    int hi;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000;

    reset = 1'b0; display_row = 11'd0; req = '0; done = '0; clear_overrun = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_tick", 32'(frame_tick), 32'h0);
    check("rst_fc", 32'(frame_count), 32'h0);
    check("rst_ov", 32'(overrun), 32'h0);
    ticks(2);
    reset = 1'b1;
    ticks(2);

    // Full round, done three cycles into each grant
    req = 4'b1011; display_row = 11'd1024;
    tick();
    check("full_busy", 32'(busy), 32'h1);
    check("full_g_e0", 32'(grant), 32'h0);
    tick();
    for (int s = 0; s < 3; s++) begin
      check("full_g_first", 32'(grant), 32'(exp_g[s]));
      for (int k = 0; k < 3; k++) begin
        tick();
        check("full_g_hold", 32'(grant), 32'(exp_g[s]));
      end
      done = 4'hF;
      tick();
      done = '0;
      check("full_g_drop", 32'(grant), 32'h0);
      tick();
    end
    check("full_g_none", 32'(grant), 32'h0);
    check("full_notick", 32'(frame_tick), 32'h0);
    tick();
    check("full_tick", 32'(frame_tick), 32'h1);
    check("full_fc", 32'(frame_count), 32'd1);
    check("full_busy_lo", 32'(busy), 32'h0);
    check("full_ov", 32'(overrun), 32'h0);
    tick();
    check("full_tick_lo", 32'(frame_tick), 32'h0);
    display_row = 11'd0;
    ticks(2);

    // Timeout: grant held exactly 4096 cycles
    req = 4'b0001; display_row = 11'd1024;
    ticks(2);
    hi = 0;
    for (int k = 0; k < 5000; k++) begin
      if (grant != 4'b0001) break;
      hi++;
      tick();
    end
    check("to_width", 32'(hi), 32'd4096);
    check("to_ov", 32'(overrun), 32'h1);
    ticks(2);
    check("to_tick", 32'(frame_tick), 32'h1);
    check("to_fc", 32'(frame_count), 32'd2);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    check("to_clear", 32'(overrun), 32'h0);
    display_row = 11'd0;
    ticks(2);

    // Vblank abort with requester 0 stuck
    req = 4'b0111; display_row = 11'd1024;
    ticks(2);
    check("ab_grant", 32'(grant), 32'h1);
    ticks(98);
    display_row = 11'd0;
    tick();
    check("ab_drop", 32'(grant), 32'h0);
    check("ab_ov", 32'(overrun), 32'h7);
    tick();
    check("ab_tick", 32'(frame_tick), 32'h1);
    check("ab_fc", 32'(frame_count), 32'd3);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    check("ab_clear", 32'(overrun), 32'h0);
    ticks(2);

    // Empty snapshot, late request served next frame
    req = 4'b0000; display_row = 11'd1024;
    tick();
    check("em_busy", 32'(busy), 32'h1);
    req = 4'b0001;
    tick();
    check("em_g0", 32'(grant), 32'h0);
    check("em_notick", 32'(frame_tick), 32'h0);
    tick();
    check("em_tick", 32'(frame_tick), 32'h1);
    check("em_g1", 32'(grant), 32'h0);
    check("em_fc", 32'(frame_count), 32'd4);
    tick();
    check("em_g2", 32'(grant), 32'h0);
    display_row = 11'd0;
    ticks(2);
    display_row = 11'd1024;
    ticks(2);
    check("em_next", 32'(grant), 32'h1);
    done = 4'b0001;
    tick();
    done = '0;
    ticks(2);
    check("em_fc2", 32'(frame_count), 32'd5);
    display_row = 11'd0;
    ticks(2);

    // done on the timeout edge: clean completion
    req = 4'b0001; display_row = 11'd1024;
    ticks(2);
    ticks(4095);
    check("dt_hold", 32'(grant), 32'h1);
    done = 4'b0001;
    tick();
    done = '0;
    check("dt_drop", 32'(grant), 32'h0);
    check("dt_ov", 32'(overrun), 32'h0);
    ticks(2);
    check("dt_fc", 32'(frame_count), 32'd6);
    display_row = 11'd0;
    ticks(2);

    // clear_overrun coincident with a timeout set
    req = 4'b0010; display_row = 11'd1024;
    ticks(2);
    check("cs_grant", 32'(grant), 32'h2);
    ticks(4095);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    check("cs_drop", 32'(grant), 32'h0);
    check("cs_ov", 32'(overrun), 32'h2);
    ticks(2);
    check("cs_fc", 32'(frame_count), 32'd7);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    display_row = 11'd0;
    ticks(2);

    // frame_count wrap
    force dut.frame_count_q = 16'hFFFF;
    tick();
    release dut.frame_count_q;
    #1;
    check("wr_pre", 32'(frame_count), 32'hFFFF);
    req = 4'b0000; display_row = 11'd1024;
    ticks(3);
    check("wr_tick", 32'(frame_tick), 32'h1);
    check("wr_fc", 32'(frame_count), 32'h0);
    display_row = 11'd0;
    ticks(2);

    // Reset while requester 1 holds the grant
    req = 4'b0011; display_row = 11'd1024;
    ticks(2);
    done = 4'b0001;
    tick();
    done = '0;
    tick();
    check("rm_grant", 32'(grant), 32'h2);
    #2;
    reset = 1'b0;
    #1;
    check("rm_grant0", 32'(grant), 32'h0);
    check("rm_busy0", 32'(busy), 32'h0);
    check("rm_fc0", 32'(frame_count), 32'h0);
    check("rm_ov0", 32'(overrun), 32'h0);
    display_row = 11'd0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rm_quiet", 32'({busy, grant}), 32'h0);
    end
    display_row = 11'd1024;
    ticks(2);
    check("rm_next", 32'(grant), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
